// File: rtl/window_ctrl.sv
// Pixel-stream window controller: tracks raster position, flags complete 6x6 windows
// for the gradient stage, and sequences one frame per start request.
//
//   state | meaning
//   IDLE  | waiting for start; no pixels accepted
//   RUN   | streaming; pixels accepted whenever no window is stalled
//   HOLD  | previous cycle stalled on an unconsumed window; resumes when down_ready=1
//   DRAIN | last pixel accepted; waiting for the final window to be consumed
module window_ctrl #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pix_valid,
    output logic       pix_ready,
    output logic       shift_en,
    input  logic       down_ready,
    output logic       win_valid,
    output logic [9:0] col,
    output logic [9:0] row,
    output logic [9:0] win_col,
    output logic [9:0] win_row,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [9:0] LAST_COL = 10'(IMG_W - 1);
    localparam logic [9:0] LAST_ROW = 10'(IMG_H - 1);
    localparam logic [9:0] WIN_OFF  = 10'd5;

    typedef enum logic [1:0] {IDLE, RUN, HOLD, DRAIN} state_t;

    state_t     state_q, state_d;
    logic [9:0] nxt_col_q, nxt_col_d;
    logic [9:0] nxt_row_q, nxt_row_d;
    logic [9:0] col_q, col_d;
    logic [9:0] row_q, row_d;
    logic [9:0] win_col_q, win_col_d;
    logic [9:0] win_row_q, win_row_d;
    logic       win_valid_q, win_valid_d;
    logic       busy_q, busy_d;
    logic       frame_done_q, frame_done_d;

    logic stall;
    logic accept;
    logic at_last;
    logic win_hit;

    always_comb begin
        stall     = win_valid_q && !down_ready;
        // Ready drops in the same cycle the window stalls, and returns in the
        // cycle down_ready rises, so streaming resumes without a bubble.
        pix_ready = ((state_q == RUN) || (state_q == HOLD)) && !stall;
        accept    = pix_valid && pix_ready;
        shift_en  = accept;
        at_last   = (nxt_col_q == LAST_COL) && (nxt_row_q == LAST_ROW);
        win_hit   = (nxt_col_q >= WIN_OFF) && (nxt_row_q >= WIN_OFF);

        state_d      = state_q;
        nxt_col_d    = nxt_col_q;
        nxt_row_d    = nxt_row_q;
        col_d        = col_q;
        row_d        = row_q;
        win_col_d    = win_col_q;
        win_row_d    = win_row_q;
        win_valid_d  = win_valid_q;
        frame_done_d = 1'b0;

        if (accept) begin
            col_d = nxt_col_q;
            row_d = nxt_row_q;
            if (nxt_col_q == LAST_COL) begin
                nxt_col_d = 10'd0;
                nxt_row_d = nxt_row_q + 10'd1;
            end else begin
                nxt_col_d = nxt_col_q + 10'd1;
            end
        end

        // A new window replaces one being consumed in the same cycle.
        if (accept && win_hit) begin
            win_valid_d = 1'b1;
            win_col_d   = nxt_col_q - WIN_OFF;
            win_row_d   = nxt_row_q - WIN_OFF;
        end else if (win_valid_q && down_ready) begin
            win_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    nxt_col_d   = 10'd0;
                    nxt_row_d   = 10'd0;
                    col_d       = 10'd0;
                    row_d       = 10'd0;
                    win_valid_d = 1'b0;
                end
            end
            RUN, HOLD: begin
                if (accept && at_last) begin
                    state_d = DRAIN;
                end else if (stall) begin
                    state_d = HOLD;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (!win_valid_q || down_ready) begin
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            nxt_col_q    <= 10'd0;
            nxt_row_q    <= 10'd0;
            col_q        <= 10'd0;
            row_q        <= 10'd0;
            win_col_q    <= 10'd0;
            win_row_q    <= 10'd0;
            win_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            nxt_col_q    <= nxt_col_d;
            nxt_row_q    <= nxt_row_d;
            col_q        <= col_d;
            row_q        <= row_d;
            win_col_q    <= win_col_d;
            win_row_q    <= win_row_d;
            win_valid_q  <= win_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign win_valid  = win_valid_q;
    assign col        = col_q;
    assign row        = row_q;
    assign win_col    = win_col_q;
    assign win_row    = win_row_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window_ctrl.sv
// Bench for window_ctrl on an 8x8 image: random and directed stimulus checked every
// cycle against a raster-count reference model.
module tb_window_ctrl;

    localparam int W    = 8;
    localparam int H    = 8;
    localparam int NPIX = W * H;
    localparam int NWIN = (W - 5) * (H - 5);

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       pix_valid = 1'b0;
    logic       down_ready = 1'b0;
    logic       pix_ready, shift_en, win_valid, busy, frame_done;
    logic [9:0] col, row, win_col, win_row;

    window_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .reset(reset), .start(start), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .shift_en(shift_en), .down_ready(down_ready),
        .win_valid(win_valid), .col(col), .row(row), .win_col(win_col),
        .win_row(win_row), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model: frame progress expressed as an accept count k.
    int m_busy = 0, m_k = 0, m_col = 0, m_row = 0;
    int m_wv = 0, m_wc = 0, m_wr = 0, m_fd = 0;

    int win_q[$];
    int acc_seen, last_acc_cyc, fd_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input bit pv, input bit dr, input bit st);
        int exp_ready, acc, r, c, in_drain;
        @(negedge clk);
        pix_valid  = pv;
        down_ready = dr;
        start      = st;
        #1;
        chk("col", 32'(col), m_col);
        chk("row", 32'(row), m_row);
        chk("win_valid", 32'(win_valid), m_wv);
        chk("win_col", 32'(win_col), m_wv ? m_wc : 32'(win_col) & 32'h3ff);
        chk("win_row", 32'(win_row), m_wv ? m_wr : 32'(win_row) & 32'h3ff);
        chk("busy", 32'(busy), m_busy);
        chk("frame_done", 32'(frame_done), m_fd);
        exp_ready = (m_busy != 0 && m_k < NPIX && !(m_wv != 0 && !dr)) ? 1 : 0;
        acc       = (pv && exp_ready != 0) ? 1 : 0;
        chk("pix_ready", 32'(pix_ready), exp_ready);
        chk("shift_en", 32'(shift_en), acc);

        if (win_valid && dr) win_q.push_back(int'(win_row) * 16 + int'(win_col));
        if (shift_en) acc_seen++;
        if (frame_done) fd_cyc = cyc;

        r = 0;
        c = 0;
        in_drain = (m_busy != 0 && m_k == NPIX) ? 1 : 0;
        m_fd = 0;
        if (m_busy == 0) begin
            if (st) begin
                m_busy = 1; m_k = 0; m_col = 0; m_row = 0; m_wv = 0;
            end
        end else begin
            if (acc != 0) begin
                r = m_k / W;
                c = m_k % W;
                m_col = c;
                m_row = r;
                m_k++;
                if (m_k == NPIX) last_acc_cyc = cyc;
            end
            if (acc != 0 && r >= 5 && c >= 5) begin
                m_wv = 1; m_wc = c - 5; m_wr = r - 5;
            end else if (m_wv != 0 && dr) begin
                m_wv = 0;
            end
            if (in_drain != 0 && m_wv == 0) begin
                m_fd = 1;
                m_busy = 0;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; pix_valid = 1'b0; start = 1'b0; down_ready = 1'b0;
        #1;
        chk("rst_pix_ready", 32'(pix_ready), 0);
        chk("rst_shift_en", 32'(shift_en), 0);
        chk("rst_win_valid", 32'(win_valid), 0);
        chk("rst_col", 32'(col), 0);
        chk("rst_row", 32'(row), 0);
        chk("rst_win_col", 32'(win_col), 0);
        chk("rst_win_row", 32'(win_row), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        m_busy = 0; m_k = 0; m_col = 0; m_row = 0;
        m_wv = 0; m_wc = 0; m_wr = 0; m_fd = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // pv_mode: 0 always, 1 toggling, 2 random. dr_mode: 0 always, 1 random, 2 five-cycle hold at first window.
    task automatic run_frame(input int pv_mode, input int dr_mode, input bit start_noise);
        int budget, bp_left, bp_done;
        bit pv, dr, st;
        win_q.delete();
        acc_seen = 0; fd_cyc = -1; last_acc_cyc = -1;
        budget = 0; bp_left = 0; bp_done = 0;
        step(1'b0, 1'b1, 1'b1);
        while ((m_busy != 0 || m_fd != 0) && budget < 3000) begin
            case (pv_mode)
                0: pv = 1'b1;
                1: pv = (budget % 2) == 0;
                default: pv = $urandom_range(0, 3) != 0;
            endcase
            case (dr_mode)
                0: dr = 1'b1;
                1: dr = $urandom_range(0, 3) != 0;
                default: begin
                    if (bp_done == 0 && m_wv != 0) begin
                        bp_left = 5;
                        bp_done = 1;
                    end
                    dr = (bp_left == 0);
                    if (bp_left > 0) bp_left--;
                end
            endcase
            st = start_noise && m_busy != 0 && m_k < NPIX && $urandom_range(0, 5) == 0;
            step(pv, dr, st);
            budget++;
        end
        chk("frame_in_budget", 32'(budget < 3000), 1);
        chk("accept_count", acc_seen, NPIX);
        chk("window_count", win_q.size(), NWIN);
        for (int i = 0; i < NWIN; i++) begin
            if (i < win_q.size()) chk("window_seq", win_q[i], (i / 3) * 16 + (i % 3));
        end
        if (pv_mode == 0 && dr_mode == 0) chk("frame_done_latency", fd_cyc - last_acc_cyc, 2);
    endtask

    initial begin
        int budget;
        do_reset();
        repeat (3) step(1'b1, 1'b1, 1'b0);

        run_frame(0, 0, 1'b0);
        run_frame(0, 2, 1'b0);
        run_frame(1, 0, 1'b0);
        repeat (3) run_frame(2, 1, 1'b1);

        step(1'b0, 1'b1, 1'b1);
        budget = 0;
        while (m_k < 30 && budget < 500) begin
            step(1'b1, 1'b1, $urandom_range(0, 3) == 0);
            budget++;
        end
        chk("midframe_reach_30", m_k, 30);
        do_reset();
        repeat (4) step(1'b1, 1'b1, 1'b0);
        run_frame(0, 0, 1'b0);

        repeat (2) step(1'b0, 1'b1, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/window_ctrl.md
WINDOW_CTRL -- requirements
Module: window_ctrl

Interface
REQ-001 The module SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter IMG_W SHALL default to 64 and set the image width in pixels (legal range 6..1024).
REQ-003 Parameter IMG_H SHALL default to 64 and set the image height in pixels (legal range 6..1024).
REQ-004 The ports SHALL be as follows:
- clk  in  1  rising-edge clock.
- reset  in  1  async active-high reset.
- start  in  1  single-cycle request to begin a frame.
- pix_valid  in  1  upstream pixel present.
- pix_ready  out  1  controller accepts a pixel.
- shift_en  out  1  advance line buffers and 6x6 window register; equals accept.
- down_ready  in  1  gradient stage consumes the window.
- win_valid  out  1  a full 6x6 window is present for the gradient stage.
- col  out  10  column of the last accepted pixel.
- row  out  10  row of the last accepted pixel.
- win_col  out  10  top-left column of the current window (col-5).
- win_row  out  10  top-left row of the current window (row-5).
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse at frame end.

Function
REQ-005 The FSM SHALL have states IDLE, RUN, HOLD and DRAIN.
REQ-006 Accept SHALL be defined as pix_valid && pix_ready, and shift_en SHALL equal accept combinationally.
REQ-007 IDLE behaviour:
- pix_ready=0 and busy=0.
- start=1 SHALL move to RUN and clear the position counters so that the next accept is (row 0, col 0).
REQ-008 In RUN, pix_ready SHALL be 1 unless win_valid=1 && down_ready=0, in which case pix_ready=0 and the FSM is in HOLD.
REQ-009 On each accept, col SHALL increment; at IMG_W-1 col SHALL wrap to 0 and row SHALL increment.
REQ-010 win_valid SHALL be registered and SHALL rise the cycle after accepting a pixel with row>=5 && col>=5. win_col and win_row SHALL update in that same cycle.
REQ-011 win_valid SHALL stay high, with win_col and win_row stable, until sampled with down_ready=1. It then SHALL clear unless a new window-producing accept occurs in the same cycle, in which case it stays 1 with the new coordinates.
REQ-012 HOLD SHALL return to RUN in the cycle down_ready=1.
REQ-013 No accept SHALL occur while in HOLD.
REQ-014 Accepting pixel (IMG_H-1, IMG_W-1) SHALL move the FSM to DRAIN with pix_ready=0.
REQ-015 DRAIN SHALL wait until win_valid is consumed, then pulse frame_done for one cycle and return to IDLE.
REQ-016 busy SHALL be 1 in RUN, HOLD and DRAIN, and 0 in IDLE.
REQ-017 Each frame SHALL produce exactly (IMG_W-5)*(IMG_H-5) windows and exactly IMG_W*IMG_H accepts.
REQ-018 start SHALL be ignored outside IDLE.
REQ-019 A pix_valid gap SHALL hold all counters and win_valid unchanged.
REQ-020 Counter arithmetic SHALL be unsigned 10-bit.
REQ-021 win_col and win_row SHALL be computed only when col>=5 and row>=5, so they never underflow.

Reset
REQ-022 While reset=1, the FSM SHALL be in IDLE and all outputs SHALL be 0: pix_ready, shift_en, win_valid, col, row, win_col, win_row, busy and frame_done.
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately without producing a frame_done pulse.
REQ-024 After reset deasserts, the module SHALL require a new start before accepting pixels.

Verification (IMG_W=IMG_H=8)
REQ-025 Streaming, pix_valid=1 and down_ready=1:
- First win_valid the cycle after the 46th accept, with win_row=0 and win_col=0.
- 9 windows total.
- Last window has win_row=2 and win_col=2.
- frame_done exactly 2 cycles after the 64th accept.
REQ-026 Backpressure, down_ready=0 for 5 cycles at the first window:
- win_valid held at (0,0) for those 5 cycles.
- pix_ready=0 and no accepts during that time.
- Streaming resumes the cycle down_ready=1.
REQ-027 Gaps, pix_valid toggled 1/0:
- Counters advance only on accept.
- Same 9 windows with the same coordinate sequence as REQ-025.
REQ-028 Wrap at pixel (row 3, col 7):
- Next accept gives col=0, row=4.
- win_valid stays 0 for row<5.
REQ-029 Mid-frame disturbances:
- Reset after 30 accepts: all outputs 0 next cycle, no frame_done, and a fresh start restarts at (0,0).
- start pulsed during RUN: ignored, counters unaffected.
